// File: rtl/instr_decode.sv
// instr_decode: second stage of the 16-bit core.
//   Decodes the IF/ID instruction, reads the 16x16 register file with a
//   write-through bypass, and registers operands, immediate and control
//   bits into the ID/EX pipeline register.
//   Detects load-use hazards (stall + bubble) and squashes on a redirect.
// Ports:
//   clk, reset (async, active-low)
//   if_id_pc/if_id_instr       : instruction in ID
//   ex_if_branch_en            : execute redirect, flush ID
//   wb_en/wb_addr/wb_data      : register file write port
//   stall                      : combinational, freezes fetch and IF/ID
//   id_ex_*                    : ID/EX pipeline register
module instr_decode (
  input  logic        clk,
  input  logic        reset,
  input  logic [15:0] if_id_pc,
  input  logic [15:0] if_id_instr,
  input  logic        ex_if_branch_en,
  input  logic        wb_en,
  input  logic [3:0]  wb_addr,
  input  logic [15:0] wb_data,
  output logic        stall,
  output logic        id_ex_valid,
  output logic [15:0] id_ex_pc,
  output logic [3:0]  id_ex_op,
  output logic [3:0]  id_ex_rd,
  output logic [15:0] id_ex_a,
  output logic [15:0] id_ex_b,
  output logic [15:0] id_ex_imm,
  output logic        id_ex_wb_en,
  output logic        id_ex_mem_r,
  output logic        id_ex_mem_w,
  output logic        id_ex_illegal
);

  typedef struct packed {
    logic        valid;
    logic [15:0] pc;
    logic [3:0]  op;
    logic [3:0]  rd;
    logic [15:0] a;
    logic [15:0] b;
    logic [15:0] imm;
    logic        wb_en;
    logic        mem_r;
    logic        mem_w;
    logic        illegal;
  } idex_t;

  // Instruction fields
  logic [3:0] op, rd, rs, rt;
  assign op = if_id_instr[15:12];
  assign rd = if_id_instr[11:8];
  assign rs = if_id_instr[7:4];
  assign rt = if_id_instr[3:0];

  // Register file; r0 is never written so it can also be forced to 0 on read
  logic [15:0] regs [16];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < 16; i++) regs[i] <= '0;
    end else if (wb_en && wb_addr != 4'd0) begin
      regs[wb_addr] <= wb_data;
    end
  end

  // Write-through bypass so a same-cycle writeback needs no stall
  logic [15:0] rd_val, rs_val, rt_val;
  assign rd_val = (rd == 4'd0) ? 16'h0 : (wb_en && wb_addr == rd) ? wb_data : regs[rd];
  assign rs_val = (rs == 4'd0) ? 16'h0 : (wb_en && wb_addr == rs) ? wb_data : regs[rs];
  assign rt_val = (rt == 4'd0) ? 16'h0 : (wb_en && wb_addr == rt) ? wb_data : regs[rt];

  idex_t dec, id_ex;
  logic  use_rd, use_rs, use_rt;

  always_comb begin
    dec     = '0;
    use_rd  = 1'b0;
    use_rs  = 1'b0;
    use_rt  = 1'b0;
    dec.valid = 1'b1;
    dec.pc    = if_id_pc;
    dec.op    = op;
    dec.rd    = rd;
    unique case (op)
      4'h1, 4'h2, 4'h3, 4'h4, 4'h5: begin
        dec.a = rs_val; dec.b = rt_val; dec.wb_en = 1'b1;
        use_rs = 1'b1; use_rt = 1'b1;
      end
      4'h6: begin
        dec.a = rd_val; dec.imm = {{8{if_id_instr[7]}}, if_id_instr[7:0]};
        dec.wb_en = 1'b1; use_rd = 1'b1;
      end
      4'h7: begin
        dec.imm = {if_id_instr[7:0], 8'h00}; dec.wb_en = 1'b1;
      end
      4'h8: begin
        dec.a = rs_val; dec.imm = {{12{if_id_instr[3]}}, if_id_instr[3:0]};
        dec.wb_en = 1'b1; dec.mem_r = 1'b1; use_rs = 1'b1;
      end
      4'h9: begin
        dec.a = rs_val; dec.b = rd_val; dec.imm = {{12{if_id_instr[3]}}, if_id_instr[3:0]};
        dec.mem_w = 1'b1; use_rs = 1'b1; use_rd = 1'b1;
      end
      4'hA: begin
        dec.a = rd_val; dec.b = rs_val; dec.imm = {{12{if_id_instr[3]}}, if_id_instr[3:0]};
        use_rd = 1'b1; use_rs = 1'b1;
      end
      4'hB: dec.imm = {4'h0, if_id_instr[11:0]};
      4'hC, 4'hD, 4'hE, 4'hF: dec.illegal = 1'b1;
      default: ;
    endcase
    // Writes to r0 are architecturally dropped, so never advertise them
    if (rd == 4'd0) dec.wb_en = 1'b0;
  end

  // Load-use: the load in EX has not produced data yet, and a redirect
  // squashes the dependent instruction anyway
  logic src_hit;
  assign src_hit = (id_ex.rd != 4'd0) &&
                   ((use_rd && rd == id_ex.rd) ||
                    (use_rs && rs == id_ex.rd) ||
                    (use_rt && rt == id_ex.rd));
  assign stall = id_ex.valid & id_ex.mem_r & src_hit & ~ex_if_branch_en;

  // First edge after reset always bubbles: IF/ID content is not yet trusted
  logic started;
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) started <= 1'b0;
    else        started <= 1'b1;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)                                  id_ex <= '0;
    else if (ex_if_branch_en || stall || !started) id_ex <= '0;
    else                                         id_ex <= dec;
  end

  assign id_ex_valid   = id_ex.valid;
  assign id_ex_pc      = id_ex.pc;
  assign id_ex_op      = id_ex.op;
  assign id_ex_rd      = id_ex.rd;
  assign id_ex_a       = id_ex.a;
  assign id_ex_b       = id_ex.b;
  assign id_ex_imm     = id_ex.imm;
  assign id_ex_wb_en   = id_ex.wb_en;
  assign id_ex_mem_r   = id_ex.mem_r;
  assign id_ex_mem_w   = id_ex.mem_w;
  assign id_ex_illegal = id_ex.illegal;

endmodule

// File: tb/tb_instr_decode.sv
// Scoreboard bench for instr_decode: the driver applies inputs at the
// falling edge, a reference model predicts stall and the next ID/EX
// contents and queues them; the monitor compares after each rising edge.
module tb_instr_decode;

  logic        clk = 1'b0;
  logic        reset;
  logic [15:0] if_id_pc, if_id_instr;
  logic        ex_if_branch_en, wb_en;
  logic [3:0]  wb_addr;
  logic [15:0] wb_data;
  logic        stall, id_ex_valid, id_ex_wb_en, id_ex_mem_r, id_ex_mem_w, id_ex_illegal;
  logic [15:0] id_ex_pc, id_ex_a, id_ex_b, id_ex_imm;
  logic [3:0]  id_ex_op, id_ex_rd;

  instr_decode dut (
    .clk(clk), .reset(reset), .if_id_pc(if_id_pc), .if_id_instr(if_id_instr),
    .ex_if_branch_en(ex_if_branch_en), .wb_en(wb_en), .wb_addr(wb_addr),
    .wb_data(wb_data), .stall(stall), .id_ex_valid(id_ex_valid),
    .id_ex_pc(id_ex_pc), .id_ex_op(id_ex_op), .id_ex_rd(id_ex_rd),
    .id_ex_a(id_ex_a), .id_ex_b(id_ex_b), .id_ex_imm(id_ex_imm),
    .id_ex_wb_en(id_ex_wb_en), .id_ex_mem_r(id_ex_mem_r),
    .id_ex_mem_w(id_ex_mem_w), .id_ex_illegal(id_ex_illegal)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic        valid;
    logic [15:0] pc;
    logic [3:0]  op;
    logic [3:0]  rd;
    logic [15:0] a;
    logic [15:0] b;
    logic [15:0] imm;
    logic        wb_en;
    logic        mem_r;
    logic        mem_w;
    logic        illegal;
  } rec_t;

  typedef struct packed {
    logic stall;
    rec_t r;
  } exp_t;

  exp_t q[$];
  int   checks = 0;
  int   errors = 0;

  // Reference model state
  int   mregs[16];
  rec_t mprev;
  bit   mstarted;

  function automatic int rd_reg(input int i);
    if (i == 0) return 0;
    if (wb_en && int'(wb_addr) == i) return int'(wb_data);
    return mregs[i];
  endfunction

  function automatic logic [15:0] sx(input int v, input int bits);
    int s;
    s = (v >= (1 << (bits - 1))) ? v - (1 << bits) : v;
    return 16'(s);
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 16; i++) mregs[i] = 0;
    mprev    = '0;
    mstarted = 0;
  endtask

  // Apply one cycle of inputs (called at a falling edge), predict, advance.
  task automatic step(input logic [15:0] instr, input logic [15:0] pc,
                      input logic br, input logic wen, input logic [3:0] waddr,
                      input logic [15:0] wdata, output logic haz);
    int   o, d, s, t;
    int   used[$];
    rec_t r;
    exp_t e;
    if_id_instr = instr; if_id_pc = pc; ex_if_branch_en = br;
    wb_en = wen; wb_addr = waddr; wb_data = wdata;
    #1;
    o = int'(instr) / 4096;
    d = (int'(instr) / 256) % 16;
    s = (int'(instr) / 16) % 16;
    t = int'(instr) % 16;
    r = '0;
    r.valid = 1'b1; r.pc = pc; r.op = 4'(o); r.rd = 4'(d);
    if (o >= 1 && o <= 5) begin
      r.a = 16'(rd_reg(s)); r.b = 16'(rd_reg(t)); r.wb_en = 1'b1; used = '{s, t};
    end else if (o == 6) begin
      r.a = 16'(rd_reg(d)); r.imm = sx(int'(instr) % 256, 8); r.wb_en = 1'b1; used = '{d};
    end else if (o == 7) begin
      r.imm = 16'((int'(instr) % 256) * 256); r.wb_en = 1'b1;
    end else if (o == 8) begin
      r.a = 16'(rd_reg(s)); r.imm = sx(t, 4); r.wb_en = 1'b1; r.mem_r = 1'b1; used = '{s};
    end else if (o == 9) begin
      r.a = 16'(rd_reg(s)); r.b = 16'(rd_reg(d)); r.imm = sx(t, 4); r.mem_w = 1'b1; used = '{s, d};
    end else if (o == 10) begin
      r.a = 16'(rd_reg(d)); r.b = 16'(rd_reg(s)); r.imm = sx(t, 4); used = '{d, s};
    end else if (o == 11) begin
      r.imm = 16'(int'(instr) % 4096);
    end else if (o >= 12) begin
      r.illegal = 1'b1;
    end
    if (d == 0) r.wb_en = 1'b0;
    haz = 1'b0;
    if (mprev.valid && mprev.mem_r && mprev.rd != 0 && !br)
      foreach (used[k]) if (used[k] == int'(mprev.rd)) haz = 1'b1;
    e.stall = haz;
    e.r = (br || haz || !mstarted) ? rec_t'('0) : r;
    q.push_back(e);
    if (wen && waddr != 0) mregs[waddr] = int'(wdata);
    mprev    = e.r;
    mstarted = 1;
    @(negedge clk);
  endtask

  // Monitor: sample stall late in the low phase, ID/EX just after the edge
  initial begin
    logic st;
    rec_t act;
    exp_t e;
    forever begin
      @(negedge clk); #4; st = stall;
      @(posedge clk); #1;
      if (q.size() > 0) begin
        e = q.pop_front();
        act = {id_ex_valid, id_ex_pc, id_ex_op, id_ex_rd, id_ex_a, id_ex_b,
               id_ex_imm, id_ex_wb_en, id_ex_mem_r, id_ex_mem_w, id_ex_illegal};
        checks += 2;
        if (st !== e.stall) begin
          errors++;
          $display("FAIL stall t=%0t got %b want %b", $time, st, e.stall);
        end
        if (act !== e.r) begin
          errors++;
          $display("FAIL idex t=%0t got %h want %h", $time, act, e.r);
        end
      end
    end
  end

  task automatic check_reset_state(input string tag);
    checks += 2;
    if (stall !== 1'b0) begin
      errors++; $display("FAIL %s_stall got %b want 0", tag, stall);
    end
    if ({id_ex_valid, id_ex_pc, id_ex_op, id_ex_rd, id_ex_a, id_ex_b, id_ex_imm,
         id_ex_wb_en, id_ex_mem_r, id_ex_mem_w, id_ex_illegal} !== '0) begin
      errors++; $display("FAIL %s_idex got nonzero outputs, want all 0", tag);
    end
  endtask

  function automatic logic [15:0] rand_instr();
    logic [3:0] o, d, s, t;
    o = 4'($urandom_range(0, 15));
    if ($urandom_range(0, 3) == 0) o = 4'h8;
    d = 4'($urandom_range(0, 4));
    s = 4'($urandom_range(0, 4));
    t = 4'($urandom_range(0, 4));
    if ($urandom_range(0, 3) == 0) return {o, d, 8'($urandom)};
    return {o, d, s, t};
  endfunction

  task automatic run_random(input int n);
    logic [15:0] ci, cp;
    logic        h;
    h  = 1'b0;
    ci = 16'h0; cp = 16'h0;
    for (int i = 0; i < n; i++) begin
      // A stalled instruction stays in IF/ID until the bubble clears it
      if (!h) begin ci = rand_instr(); cp = 16'($urandom); end
      step(ci, cp, ($urandom_range(0, 9) == 0), ($urandom_range(0, 1) == 1),
           4'($urandom_range(0, 5)), 16'($urandom), h);
    end
  endtask

  initial begin
    logic h;
    reset = 1'b1;
    if_id_pc = '0; if_id_instr = '0; ex_if_branch_en = 1'b0;
    wb_en = 1'b0; wb_addr = '0; wb_data = '0;
    model_reset();
    #1 reset = 1'b0;
    #1 check_reset_state("reset");
    @(negedge clk); @(negedge clk);
    reset = 1'b1;

    // First edge after release bubbles, second issues ADD r1,r2,r3
    step(16'h1123, 16'h0010, 0, 0, 4'd0, 16'h0, h);
    step(16'h1123, 16'h0010, 0, 1, 4'd2, 16'h2222, h);
    step(16'h1123, 16'h0012, 0, 1, 4'd3, 16'h3333, h);
    // Same-cycle writeback seen through the bypass
    step(16'h1150, 16'h0014, 0, 1, 4'd5, 16'hBEEF, h);
    // Load-use: one stall, bubble, then the ADD issues
    step(16'h8421, 16'h0016, 0, 0, 4'd0, 16'h0, h);
    step(16'h1644, 16'h0018, 0, 0, 4'd0, 16'h0, h);
    step(16'h1644, 16'h0018, 0, 0, 4'd0, 16'h0, h);
    // LUI after load into same rd: no source, no stall
    step(16'h8421, 16'h001A, 0, 0, 4'd0, 16'h0, h);
    step(16'h7412, 16'h001C, 0, 0, 4'd0, 16'h0, h);
    // Flush while the hazard condition holds, then plain flush
    step(16'h8421, 16'h001E, 0, 0, 4'd0, 16'h0, h);
    step(16'h1644, 16'h0020, 1, 0, 4'd0, 16'h0, h);
    step(16'h1123, 16'h0022, 1, 0, 4'd0, 16'h0, h);
    // ADDI r0 (no writeback), illegal opcode, r0 write ignored
    step(16'h60FF, 16'h0024, 0, 0, 4'd0, 16'h0, h);
    step(16'hD000, 16'h0026, 0, 0, 4'd0, 16'h0, h);
    step(16'h1100, 16'h0028, 0, 1, 4'd0, 16'h1234, h);
    step(16'h1100, 16'h002A, 0, 0, 4'd0, 16'h0, h);

    run_random(400);

    // Mid-operation reset: immediate clear, then the first instruction bubbles
    @(posedge clk); #2;
    reset = 1'b0;
    #1 check_reset_state("midreset");
    model_reset();
    @(negedge clk); @(negedge clk);
    reset = 1'b1;
    step(16'h1123, 16'h0100, 0, 0, 4'd0, 16'h0, h);
    step(16'h1123, 16'h0102, 0, 0, 4'd0, 16'h0, h);
    run_random(100);

    repeat (3) @(negedge clk);
    checks++;
    if (q.size() != 0) begin
      errors++; $display("FAIL drain got %0d pending want 0", q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
